ex_mem_wb_stage: RTL and testbench

//  Downstream neighbour of the execute stage: EX/MEM pipeline register, 64-bit doubleword data memory
//  (ld/sd), MEM/WB pipeline register. Consumes the ALU result and store operand, performs the access, and

---
 rtl/ex_mem_wb_stage_pkg.sv | 37 +++
 rtl/ex_mem_wb_stage_data_mem.sv | 36 +++
 rtl/ex_mem_wb_stage.sv | 127 ++++++++++++
 tb/tb_ex_mem_wb_stage.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_mem_wb_stage_pkg.sv
// Shared widths, the EX/MEM payload struct and the address-fault helper for the
// EX/MEM/WB back end.
//
// Contents:
//   XLEN, REG_AW, DW_BYTES  datapath width, register index width, bytes per doubleword
//   DEPTH_DEF, AW_DEF       default data memory geometry
//   exmem_t                 EX/MEM pipeline register payload
//   addr_fault()            misaligned or out-of-range doubleword address test
package ex_mem_wb_stage_pkg;

    localparam int unsigned XLEN      = 64;
    localparam int unsigned REG_AW    = 5;
    localparam int unsigned DW_BYTES  = 8;
    localparam int unsigned DEPTH_DEF = 256;
    localparam int unsigned AW_DEF    = 8;

    // Control bits are already qualified by valid when the register is loaded.
    typedef struct packed {
        logic              valid;
        logic [XLEN-1:0]   result;
        logic [XLEN-1:0]   store_data;
        logic [REG_AW-1:0] rd;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
    } exmem_t;

    // A doubleword access faults when it is not 8-byte aligned or when it lies
    // beyond the end of a memory with 2**aw doublewords.
    function automatic logic addr_fault(input logic [XLEN-1:0] addr,
                                        input int unsigned aw);
        logic [XLEN-1:0] upper;
        upper = addr >> (aw + 3);
        return (addr[2:0] != 3'd0) || (upper != '0);
    endfunction

endpackage

// File: rtl/ex_mem_wb_stage_data_mem.sv
// Data memory: DEPTH x XLEN doublewords, single port, asynchronous read,
// synchronous write. Write enable is fully qualified by the parent. Contents are
// never reset.
//
// Ports:
//   clk    rising-edge clock
//   we     write enable, qualified by the parent
//   addr   doubleword index
//   wdata  write data
//   rdata  asynchronous read data at addr
module ex_mem_wb_stage_data_mem
    import ex_mem_wb_stage_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEF,
    parameter int unsigned AW    = AW_DEF
) (
    input  logic            clk,
    input  logic            we,
    input  logic [AW-1:0]   addr,
    input  logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] rdata
);

    logic [XLEN-1:0] mem [DEPTH];

    // Synchronous write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    // Asynchronous read port.
    assign rdata = mem[addr];

endmodule

// File: rtl/ex_mem_wb_stage.sv
// EX/MEM pipeline register, doubleword data memory (ld/sd) and MEM/WB pipeline
// register. Delivers writeback data and forwarding info to the hazard logic.
//
// Optional feature macro: MEM_BOUNDS_CHECK_EN
//   defined   : misaligned or out-of-range accesses fault (sd suppressed,
//               ld returns 0) and set the sticky mem_fault flag
//   undefined : low address bits and upper bits are ignored, mem_fault tied 0
//
// Ports:
//   clk, rst                synchronous active-high reset
//   ex_valid .. ex_mem_write instruction presented by the execute stage
//   stall                   freezes both stage registers
//   flush                   squashes the instruction entering EX/MEM
//   fwd_rd, fwd_reg_write, fwd_data, load_pending   EX/MEM forwarding view
//   wb_valid, wb_rd, wb_reg_write, wb_data          MEM/WB writeback view
//   mem_fault               sticky access fault flag
module ex_mem_wb_stage
    import ex_mem_wb_stage_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEF,
    parameter int unsigned AW    = AW_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    input  logic [XLEN-1:0]   ex_result,
    input  logic [XLEN-1:0]   ex_store_data,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_reg_write,
    input  logic              ex_mem_read,
    input  logic              ex_mem_write,
    input  logic              stall,
    input  logic              flush,
    output logic [REG_AW-1:0] fwd_rd,
    output logic              fwd_reg_write,
    output logic [XLEN-1:0]   fwd_data,
    output logic              load_pending,
    output logic              wb_valid,
    output logic [REG_AW-1:0] wb_rd,
    output logic              wb_reg_write,
    output logic [XLEN-1:0]   wb_data,
    output logic              mem_fault
);

    exmem_t          em_q;
    logic [AW-1:0]   mem_idx_c;
    logic [XLEN-1:0] mem_rdata_c;
    logic [XLEN-1:0] load_data_c;
    logic            em_fault_c;
    logic            mem_we_c;

    // EX/MEM register: flush beats stall; a read+write instruction is a store.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            em_q <= '0;
        end else if (!stall) begin
            em_q.valid      <= ex_valid;
            em_q.result     <= ex_result;
            em_q.store_data <= ex_store_data;
            em_q.rd         <= ex_rd;
            em_q.reg_write  <= ex_valid & ex_reg_write;
            em_q.mem_read   <= ex_valid & ex_mem_read & ~ex_mem_write;
            em_q.mem_write  <= ex_valid & ex_mem_write;
        end
    end

    assign mem_idx_c = em_q.result[AW+2:3];

`ifdef MEM_BOUNDS_CHECK_EN
    assign em_fault_c = em_q.valid & (em_q.mem_read | em_q.mem_write)
                        & addr_fault(em_q.result, AW);
`else
    assign em_fault_c = 1'b0;
`endif

    // The store commits only on the edge where it leaves EX/MEM, so a stalled
    // store writes exactly once.
    assign mem_we_c = em_q.valid & em_q.mem_write & ~stall & ~rst & ~em_fault_c;

    ex_mem_wb_stage_data_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_data_mem (
        .clk   (clk),
        .we    (mem_we_c),
        .addr  (mem_idx_c),
        .wdata (em_q.store_data),
        .rdata (mem_rdata_c)
    );

    assign load_data_c = em_fault_c ? XLEN'(0) : mem_rdata_c;

    // MEM/WB register: holds on stall, unaffected by flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid     <= 1'b0;
            wb_rd        <= '0;
            wb_reg_write <= 1'b0;
            wb_data      <= '0;
        end else if (!stall) begin
            wb_valid     <= em_q.valid;
            wb_rd        <= em_q.rd;
            wb_reg_write <= em_q.valid & em_q.reg_write & (em_q.rd != REG_AW'(0));
            wb_data      <= em_q.mem_read ? load_data_c : em_q.result;
        end
    end

`ifdef MEM_BOUNDS_CHECK_EN
    // Sticky fault: set when a faulting access leaves EX/MEM, cleared by rst only.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_fault <= 1'b0;
        end else if (em_fault_c && !stall) begin
            mem_fault <= 1'b1;
        end
    end
`else
    assign mem_fault = 1'b0;
`endif

    // Forwarding view of the EX/MEM register.
    assign fwd_rd        = em_q.rd;
    assign fwd_data      = em_q.result;
    assign fwd_reg_write = em_q.valid & em_q.reg_write & ~em_q.mem_read;
    assign load_pending  = em_q.valid & em_q.mem_read;

endmodule

// File: tb/tb_ex_mem_wb_stage.sv
// Self-checking bench for ex_mem_wb_stage: directed scenarios followed by random
// traffic, all outputs compared every cycle against an instruction-level model.
module tb_ex_mem_wb_stage;

    logic        clk = 1'b0;
    logic        rst, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, stall, flush;
    logic [63:0] ex_result, ex_store_data;
    logic [4:0]  ex_rd;
    logic [4:0]  fwd_rd, wb_rd;
    logic        fwd_reg_write, load_pending, wb_valid, wb_reg_write, mem_fault;
    logic [63:0] fwd_data, wb_data;

    always #5 clk = ~clk;

    ex_mem_wb_stage dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_result(ex_result),
        .ex_store_data(ex_store_data), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .stall(stall),
        .flush(flush), .fwd_rd(fwd_rd), .fwd_reg_write(fwd_reg_write),
        .fwd_data(fwd_data), .load_pending(load_pending), .wb_valid(wb_valid),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_data(wb_data),
        .mem_fault(mem_fault)
    );

    // Reference model: one in-flight instruction per slot plus a flat memory.
    typedef struct {
        bit          v;
        logic [63:0] res;
        logic [63:0] sd;
        logic [4:0]  rd;
        bit          rw;
        bit          ld;
        bit          st;
    } ins_t;

    ins_t        m_em;
    bit          m_wv, m_wrw, m_fault;
    logic [4:0]  m_wrd;
    logic [63:0] m_wdata;
    logic [63:0] mmem [256];

    int checks = 0;
    int errors = 0;

    function automatic ins_t bubble();
        ins_t b;
        b.v = 0; b.res = '0; b.sd = '0; b.rd = '0; b.rw = 0; b.ld = 0; b.st = 0;
        return b;
    endfunction

    function automatic bit is_fault(ins_t i);
        bit bad;
        bad = (i.res % 8 != 0) || (i.res >= 64'd2048);
`ifdef MEM_BOUNDS_CHECK_EN
        return i.v && (i.ld || i.st) && bad;
`else
        return bad && 1'b0;
`endif
    endfunction

    function automatic int word_of(logic [63:0] a);
        return int'((a / 8) % 256);
    endfunction

    // Advance the model by one clock edge using the current inputs.
    task automatic model_step();
        ins_t nx;
        bit   f;
        f = is_fault(m_em);
        if (rst) begin
            m_em = bubble();
            m_wv = 0; m_wrd = '0; m_wrw = 0; m_wdata = '0; m_fault = 0;
            return;
        end
        if (!stall) begin
            m_wv    = m_em.v;
            m_wrd   = m_em.rd;
            m_wrw   = m_em.v && m_em.rw && (m_em.rd != 0);
            m_wdata = m_em.ld ? (f ? 64'd0 : mmem[word_of(m_em.res)]) : m_em.res;
            if (m_em.v && m_em.st && !f) mmem[word_of(m_em.res)] = m_em.sd;
            if (f) m_fault = 1;
        end
        if (flush) begin
            m_em = bubble();
        end else if (!stall) begin
            nx.v   = ex_valid;
            nx.res = ex_result;
            nx.sd  = ex_store_data;
            nx.rd  = ex_rd;
            nx.rw  = ex_valid && ex_reg_write;
            nx.st  = ex_valid && ex_mem_write;
            nx.ld  = ex_valid && ex_mem_read && !ex_mem_write;
            m_em   = nx;
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("fwd_rd",        64'(fwd_rd),        64'(m_em.rd));
        chk("fwd_data",      fwd_data,           m_em.res);
        chk("fwd_reg_write", 64'(fwd_reg_write), 64'(m_em.v && m_em.rw && !m_em.ld));
        chk("load_pending",  64'(load_pending),  64'(m_em.v && m_em.ld));
        chk("wb_valid",      64'(wb_valid),      64'(m_wv));
        chk("wb_rd",         64'(wb_rd),         64'(m_wrd));
        chk("wb_reg_write",  64'(wb_reg_write),  64'(m_wrw));
        chk("wb_data",       wb_data,            m_wdata);
        chk("mem_fault",     64'(mem_fault),     64'(m_fault));
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic setin(input bit v, input logic [63:0] res, input logic [63:0] sd,
                         input logic [4:0] rd, input bit rw, input bit ld, input bit st);
        ex_valid = v; ex_result = res; ex_store_data = sd; ex_rd = rd;
        ex_reg_write = rw; ex_mem_read = ld; ex_mem_write = st;
    endtask

    task automatic idle();
        setin(0, '0, '0, '0, 0, 0, 0);
    endtask

    logic [63:0] saved;

    initial begin
        m_em = bubble();
        m_wv = 0; m_wrd = '0; m_wrw = 0; m_wdata = '0; m_fault = 0;
        rst = 1; stall = 0; flush = 0;
        idle();
        #1;
        tick();
        tick();
        chk("rst_wb_valid", 64'(wb_valid), 64'd0);
        chk("rst_wb_data",  wb_data,       64'd0);
        chk("rst_fwd_data", fwd_data,      64'd0);
        rst = 0;

        // Fill every word so that later loads have defined contents.
        for (int i = 0; i < 256; i++) begin
            setin(1, 64'(i * 8), {$urandom, $urandom}, 5'd0, 0, 0, 1);
            tick();
        end
        idle(); tick(); tick();

        // Store then load the same address back to back.
        setin(1, 64'h40, 64'hDEADBEEF_CAFEF00D, 5'd5, 0, 0, 1); tick();
        setin(1, 64'h40, '0, 5'd7, 1, 1, 0); tick();
        idle(); tick();
        chk("t1_wb_rd",   64'(wb_rd), 64'd7);
        chk("t1_wb_data", wb_data,    64'hDEADBEEF_CAFEF00D);

        // Forwarding view of an ALU op and of a load.
        setin(1, 64'h1234, '0, 5'd3, 1, 0, 0); tick();
        chk("t2_fwd_rd",   64'(fwd_rd),        64'd3);
        chk("t2_fwd_rw",   64'(fwd_reg_write), 64'd1);
        chk("t2_fwd_data", fwd_data,           64'h1234);
        setin(1, 64'h100, '0, 5'd4, 1, 1, 0); tick();
        chk("t2_load_pending", 64'(load_pending),  64'd1);
        chk("t2_fwd_rw_ld",    64'(fwd_reg_write), 64'd0);
        idle(); tick(); tick();

        // Store held three cycles by stall.
        setin(1, 64'h999, '0, 5'd9, 1, 0, 0); tick();
        setin(1, 64'h80, 64'h0123_4567_89AB_CDEF, 5'd0, 0, 0, 1); tick();
        idle(); stall = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t3_wb_rd_frozen",   64'(wb_rd), 64'd9);
            chk("t3_wb_data_frozen", wb_data,    64'h999);
        end
        stall = 0; tick();
        setin(1, 64'h80, '0, 5'd10, 1, 1, 0); tick();
        idle(); tick();
        chk("t3_ld_data", wb_data, 64'h0123_4567_89AB_CDEF);

        // Flush together with stall while a store is presented.
        saved = mmem[24];
        stall = 1; flush = 1;
        setin(1, 64'hC0, 64'h5555_AAAA_5555_AAAA, 5'd0, 0, 0, 1); tick();
        stall = 0; flush = 0; idle(); tick(); tick();
        chk("t4_wb_valid", 64'(wb_valid), 64'd0);
        setin(1, 64'hC0, '0, 5'd11, 1, 1, 0); tick();
        idle(); tick();
        chk("t4_mem_kept", wb_data, saved);

        // Reset with a store sitting in EX/MEM.
        saved = mmem[9];
        setin(1, 64'h48, 64'h7777_0000_7777_0000, 5'd0, 0, 0, 1); tick();
        idle(); rst = 1; tick();
        chk("t5_fwd_data", fwd_data,           64'd0);
        chk("t5_wb_valid", 64'(wb_valid),      64'd0);
        chk("t5_ldpend",   64'(load_pending),  64'd0);
        rst = 0;
        setin(1, 64'h48, '0, 5'd12, 1, 1, 0); tick();
        idle(); tick();
        chk("t5_mem_kept", wb_data, saved);
        setin(1, 64'h5, '0, 5'd0, 1, 0, 0); tick();
        idle(); tick();
        chk("t5_rd0_valid", 64'(wb_valid),     64'd1);
        chk("t5_rd0_write", 64'(wb_reg_write), 64'd0);

        // Misaligned load.
        setin(1, 64'h43, '0, 5'd13, 1, 1, 0); tick();
        idle(); tick();
`ifdef MEM_BOUNDS_CHECK_EN
        chk("t6_wb_data", wb_data,         64'd0);
        chk("t6_fault",   64'(mem_fault),  64'd1);
        tick(); tick();
        chk("t6_sticky",  64'(mem_fault),  64'd1);
`else
        chk("t6_wb_data", wb_data,         64'hDEADBEEF_CAFEF00D);
        chk("t6_fault",   64'(mem_fault),  64'd0);
`endif

        // Random traffic.
        for (int n = 0; n < 800; n++) begin
            logic [63:0] a;
            int unsigned op;
            if ($urandom_range(0, 7) == 0)
                a = {$urandom, $urandom};
            else
                a = 64'($urandom_range(0, 255) * 8);
            op = $urandom_range(0, 3);
            setin($urandom_range(0, 4) != 0, a, {$urandom, $urandom},
                  5'($urandom_range(0, 31)), op != 2, op == 1 || op == 3, op >= 2);
            stall = ($urandom_range(0, 4) == 0);
            flush = ($urandom_range(0, 9) == 0);
            rst   = ($urandom_range(0, 63) == 0);
            tick();
        end
        rst = 0; stall = 0; flush = 0; idle();
        tick(); tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
